// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment readback monitor.
// Segment patterns are active-low, bit0 = a ... bit6 = g.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;
  localparam int SEG_W      = 7;
  localparam int CNT_W      = 8;

  localparam logic [SEG_W-1:0] SEG_0     = 7'h40;
  localparam logic [SEG_W-1:0] SEG_1     = 7'h79;
  localparam logic [SEG_W-1:0] SEG_2     = 7'h24;
  localparam logic [SEG_W-1:0] SEG_3     = 7'h30;
  localparam logic [SEG_W-1:0] SEG_4     = 7'h19;
  localparam logic [SEG_W-1:0] SEG_5     = 7'h12;
  localparam logic [SEG_W-1:0] SEG_6     = 7'h02;
  localparam logic [SEG_W-1:0] SEG_7     = 7'h78;
  localparam logic [SEG_W-1:0] SEG_8     = 7'h00;
  localparam logic [SEG_W-1:0] SEG_9     = 7'h10;
  localparam logic [SEG_W-1:0] SEG_A     = 7'h08;
  localparam logic [SEG_W-1:0] SEG_B     = 7'h03;
  localparam logic [SEG_W-1:0] SEG_C     = 7'h46;
  localparam logic [SEG_W-1:0] SEG_D     = 7'h21;
  localparam logic [SEG_W-1:0] SEG_E     = 7'h06;
  localparam logic [SEG_W-1:0] SEG_F     = 7'h0E;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic [1:0] REG_DIGITS = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CHANGE = 2'd2;
  localparam logic [1:0] REG_IRQ_EN = 2'd3;

  typedef struct packed {
    logic [3:0] nibble;
    logic       valid;
    logic       blank;
  } seg7_dec_t;

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment pattern -> hex nibble decoder.
// Blank and unrecognised patterns both report nibble 0 with valid low.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output seg7_dec_t        dec_o
);

  always_comb begin
    dec_o       = '0;
    dec_o.valid = 1'b1;
    case (seg_i)
      SEG_0:     dec_o.nibble = 4'h0;
      SEG_1:     dec_o.nibble = 4'h1;
      SEG_2:     dec_o.nibble = 4'h2;
      SEG_3:     dec_o.nibble = 4'h3;
      SEG_4:     dec_o.nibble = 4'h4;
      SEG_5:     dec_o.nibble = 4'h5;
      SEG_6:     dec_o.nibble = 4'h6;
      SEG_7:     dec_o.nibble = 4'h7;
      SEG_8:     dec_o.nibble = 4'h8;
      SEG_9:     dec_o.nibble = 4'h9;
      SEG_A:     dec_o.nibble = 4'hA;
      SEG_B:     dec_o.nibble = 4'hB;
      SEG_C:     dec_o.nibble = 4'hC;
      SEG_D:     dec_o.nibble = 4'hD;
      SEG_E:     dec_o.nibble = 4'hE;
      SEG_F:     dec_o.nibble = 4'hF;
      SEG_BLANK: begin
        dec_o.valid = 1'b0;
        dec_o.blank = 1'b1;
      end
      default:   dec_o.valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_readback.sv
// Round-robin, debounced readback of eight 7-segment buses with an
// Avalon-MM register view (digits, status, sticky change flags, irq).
module seg7_readback
  import seg7_pkg::*;
#(
  parameter int STABLE_COUNT = 4
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  input  logic [SEG_W-1:0] seg0_export,
  input  logic [SEG_W-1:0] seg1_export,
  input  logic [SEG_W-1:0] seg2_export,
  input  logic [SEG_W-1:0] seg3_export,
  input  logic [SEG_W-1:0] seg4_export,
  input  logic [SEG_W-1:0] seg5_export,
  input  logic [SEG_W-1:0] seg6_export,
  input  logic [SEG_W-1:0] seg7_export,
  input  logic [1:0]       avs_address,
  input  logic             avs_read,
  output logic [31:0]      avs_readdata,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic             irq
);

  localparam logic [CNT_W-1:0] STABLE_CNT = CNT_W'(STABLE_COUNT);

  logic [NUM_DIGITS-1:0][SEG_W-1:0] seg_in;
  assign seg_in = {seg7_export, seg6_export, seg5_export, seg4_export,
                   seg3_export, seg2_export, seg1_export, seg0_export};

  logic [2:0]                        scan_idx_q, scan_idx_d;
  logic [NUM_DIGITS-1:0][SEG_W-1:0]  last_q, last_d;
  logic [NUM_DIGITS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0][3:0]        digits_q, digits_d;
  logic [NUM_DIGITS-1:0]             valid_q, valid_d;
  logic [NUM_DIGITS-1:0]             blank_q, blank_d;
  logic [NUM_DIGITS-1:0]             change_q, change_d;
  logic [NUM_DIGITS-1:0]             irq_en_q, irq_en_d;
  logic                              irq_q, irq_d;
  logic [31:0]                       rdata_q, rdata_d;

  logic [SEG_W-1:0]      raw;
  logic [SEG_W-1:0]      cur_last;
  logic [CNT_W-1:0]      cur_cnt;
  logic                  commit;
  seg7_dec_t             dec;
  logic [NUM_DIGITS-1:0] change_set;
  logic [NUM_DIGITS-1:0] change_clr;
  logic                  unused_wdata;

  assign unused_wdata = ^avs_writedata[31:NUM_DIGITS];

  // One decoder serves all digits through the scan multiplexer.
  assign raw = seg_in[scan_idx_q];

  seg7_decode u_decode (
    .seg_i (raw),
    .dec_o (dec)
  );

  assign scan_idx_d = scan_idx_q + 3'd1;

  // Debounce: the visited digit restarts on any change and commits only on
  // the visit that first brings its count up to STABLE_COUNT.
  always_comb begin
    last_d   = last_q;
    cnt_d    = cnt_q;
    commit   = 1'b0;
    cur_last = last_q[scan_idx_q];
    cur_cnt  = cnt_q[scan_idx_q];
    if (raw != cur_last) begin
      last_d[scan_idx_q] = raw;
      cnt_d[scan_idx_q]  = CNT_W'(1);
      commit             = (STABLE_CNT == CNT_W'(1));
    end else if (cur_cnt != STABLE_CNT) begin
      cnt_d[scan_idx_q]  = cur_cnt + CNT_W'(1);
      commit             = ((cur_cnt + CNT_W'(1)) == STABLE_CNT);
    end
  end

  always_comb begin
    digits_d   = digits_q;
    valid_d    = valid_q;
    blank_d    = blank_q;
    change_set = '0;
    if (commit) begin
      digits_d[scan_idx_q]   = dec.nibble;
      valid_d[scan_idx_q]    = dec.valid;
      blank_d[scan_idx_q]    = dec.blank;
      change_set[scan_idx_q] = (digits_q[scan_idx_q] != dec.nibble) ||
                               (valid_q[scan_idx_q]  != dec.valid)  ||
                               (blank_q[scan_idx_q]  != dec.blank);
    end
  end

  // A commit setting a flag overrides a W1C of the same bit.
  always_comb begin
    change_clr = '0;
    if (avs_write && avs_address == REG_CHANGE) begin
      change_clr = avs_writedata[NUM_DIGITS-1:0];
    end
    change_d = (change_q & ~change_clr) | change_set;
    irq_en_d = irq_en_q;
    if (avs_write && avs_address == REG_IRQ_EN) begin
      irq_en_d = avs_writedata[NUM_DIGITS-1:0];
    end
    irq_d = |(change_q & irq_en_q);
  end

  // Reads sample the registers before this edge's commit/write.
  always_comb begin
    rdata_d = rdata_q;
    if (avs_read) begin
      case (avs_address)
        REG_DIGITS: rdata_d = digits_q;
        REG_STATUS: rdata_d = {16'h0000, blank_q, valid_q};
        REG_CHANGE: rdata_d = {24'h000000, change_q};
        REG_IRQ_EN: rdata_d = {24'h000000, irq_en_q};
        default:    rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      scan_idx_q <= '0;
      last_q     <= {NUM_DIGITS{SEG_BLANK}};
      cnt_q      <= {NUM_DIGITS{STABLE_CNT}};
      digits_q   <= '0;
      valid_q    <= '0;
      blank_q    <= '1;
      change_q   <= '0;
      irq_en_q   <= '0;
      irq_q      <= 1'b0;
      rdata_q    <= '0;
    end else begin
      scan_idx_q <= scan_idx_d;
      last_q     <= last_d;
      cnt_q      <= cnt_d;
      digits_q   <= digits_d;
      valid_q    <= valid_d;
      blank_q    <= blank_d;
      change_q   <= change_d;
      irq_en_q   <= irq_en_d;
      irq_q      <= irq_d;
      rdata_q    <= rdata_d;
    end
  end

  assign avs_readdata = rdata_q;
  assign irq          = irq_q;

endmodule

// File: tb/tb_seg7_readback.sv
// Directed bench for seg7_readback with STABLE_COUNT = 4.
// Scan phase is tracked from reset release so commit edges are predicted.
module tb_seg7_readback;

  logic        clk;
  logic        rst_n;
  logic [6:0]  seg [8];
  logic [1:0]  avs_address;
  logic        avs_read;
  logic [31:0] avs_readdata;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic        irq;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  seg7_readback #(.STABLE_COUNT(4)) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .seg0_export   (seg[0]),
    .seg1_export   (seg[1]),
    .seg2_export   (seg[2]),
    .seg3_export   (seg[3]),
    .seg4_export   (seg[4]),
    .seg5_export   (seg[5]),
    .seg6_export   (seg[6]),
    .seg7_export   (seg[7]),
    .avs_address   (avs_address),
    .avs_read      (avs_read),
    .avs_readdata  (avs_readdata),
    .avs_write     (avs_write),
    .avs_writedata (avs_writedata),
    .irq           (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  // All bus tasks start and end on a falling edge.
  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    avs_address = a;
    avs_read    = 1'b1;
    @(posedge clk);
    @(negedge clk);
    avs_read = 1'b0;
    d = avs_readdata;
  endtask

  task automatic rd_chk(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    check(tag, d, exp);
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    avs_address   = a;
    avs_writedata = d;
    avs_write     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    avs_write = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  // First edge after `after` on which digit d is visited (digit i is
  // visited on edge base+1+i, then every 8 edges).
  function automatic int next_visit(input int d, input int after, input int base);
    int e;
    e = after + 1;
    while (((e - base - 1 - d) % 8) != 0) e++;
    return e;
  endfunction

  initial begin
    logic [31:0] d;
    int r0, r1, t;

    rst_n = 1'b0;
    avs_address = '0; avs_read = 1'b0; avs_write = 1'b0; avs_writedata = '0;
    for (int i = 0; i < 8; i++) seg[i] = 7'h7F;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_rdata", avs_readdata, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    rst_n = 1'b1;
    r0 = cyc;
    rd_chk("rst_digits", 2'd0, 32'h0000_0000);
    rd_chk("rst_status", 2'd1, 32'h0000_FF00);
    rd_chk("rst_change", 2'd2, 32'h0000_0000);
    rd_chk("rst_irq_en", 2'd3, 32'h0000_0000);
    repeat (20) @(negedge clk);
    rd_chk("idle_change", 2'd2, 32'h0000_0000);

    // Full commit of 0..7
    seg[0] = 7'h40; seg[1] = 7'h79; seg[2] = 7'h24; seg[3] = 7'h30;
    seg[4] = 7'h19; seg[5] = 7'h12; seg[6] = 7'h02; seg[7] = 7'h78;
    repeat (34) @(negedge clk);
    rd_chk("full_digits", 2'd0, 32'h7654_3210);
    rd_chk("full_status", 2'd1, 32'h0000_00FF);
    rd_chk("full_change", 2'd2, 32'h0000_00FF);
    check("full_irq_off", {31'b0, irq}, 32'h0);

    // RO writes ignored, W1C clears
    wr(2'd0, 32'hFFFF_FFFF);
    wr(2'd1, 32'hFFFF_FFFF);
    rd_chk("ro_digits", 2'd0, 32'h7654_3210);
    rd_chk("ro_status", 2'd1, 32'h0000_00FF);
    wr(2'd2, 32'h0000_00FF);
    rd_chk("w1c_all", 2'd2, 32'h0000_0000);

    // Debounce: seg3 bounces between 8 and 9 every scan period
    for (int k = 0; k < 10; k++) begin
      seg[3] = 7'h00; repeat (8) @(negedge clk);
      seg[3] = 7'h10; repeat (8) @(negedge clk);
    end
    seg[3] = 7'h00;
    rd_chk("bounce_digits", 2'd0, 32'h7654_3210);
    rd_chk("bounce_change", 2'd2, 32'h0000_0000);
    seg[3] = 7'h10;
    repeat (34) @(negedge clk);
    rd_chk("settle_digits", 2'd0, 32'h7654_9210);
    rd_chk("settle_change", 2'd2, 32'h0000_0008);
    wr(2'd2, 32'h0000_0008);

    // Invalid pattern on seg5, blank on seg6
    seg[5] = 7'h55;
    seg[6] = 7'h7F;
    repeat (34) @(negedge clk);
    rd_chk("inv_digits", 2'd0, 32'h7004_9210);
    rd_chk("inv_status", 2'd1, 32'h0000_409F);
    rd_chk("inv_change", 2'd2, 32'h0000_0060);
    wr(2'd2, 32'h0000_0060);

    // Interrupt rise one cycle after change[2] sets
    wr(2'd3, 32'h0000_0004);
    t = next_visit(2, cyc, r0);
    wait_cyc(t - 1);
    seg[2] = 7'h06;
    wait_cyc(t + 23);
    check("irq_pre_commit", {31'b0, irq}, 32'h0);
    @(negedge clk);
    check("irq_at_commit", {31'b0, irq}, 32'h0);
    rd(2'd2, d);
    check("irq_change_bit", d, 32'h0000_0004);
    check("irq_rise", {31'b0, irq}, 32'h1);

    // W1C drops irq the following cycle
    wr(2'd2, 32'h0000_0004);
    check("irq_hold_w1c", {31'b0, irq}, 32'h1);
    @(negedge clk);
    check("irq_fall_w1c", {31'b0, irq}, 32'h0);

    // Commit on seg2 coinciding with W1C of bit 2: set wins
    t = next_visit(2, cyc, r0);
    wait_cyc(t - 1);
    seg[2] = 7'h0E;
    wait_cyc(t + 23);
    avs_address = 2'd2; avs_writedata = 32'h0000_0004; avs_write = 1'b1;
    @(posedge clk);
    @(negedge clk);
    avs_write = 1'b0;
    rd_chk("setwins_change", 2'd2, 32'h0000_0004);
    check("setwins_irq", {31'b0, irq}, 32'h1);
    rd_chk("setwins_digits", 2'd0, 32'h7004_9F10);

    // Clearing IRQ_EN drops irq the following cycle
    wr(2'd3, 32'h0000_0000);
    check("en_clr_hold", {31'b0, irq}, 32'h1);
    @(negedge clk);
    check("en_clr_fall", {31'b0, irq}, 32'h0);
    wr(2'd3, 32'h0000_0084);
    rd_chk("irq_en_rw", 2'd3, 32'h0000_0084);
    check("irq_reenabled", {31'b0, irq}, 32'h1);

    // Reset mid-debounce with seg1 at count 2
    t = next_visit(1, cyc, r0);
    wait_cyc(t - 1);
    seg[1] = 7'h12;
    wait_cyc(t + 9);
    rst_n = 1'b0;
    #1;
    check("mid_rst_rdata", avs_readdata, 32'h0);
    check("mid_rst_irq", {31'b0, irq}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    r1 = cyc;
    rd_chk("post_rst_digits", 2'd0, 32'h0000_0000);
    rd_chk("post_rst_status", 2'd1, 32'h0000_FF00);
    rd_chk("post_rst_change", 2'd2, 32'h0000_0000);
    rd_chk("post_rst_irq_en", 2'd3, 32'h0000_0000);
    // seg1 visits at r1+2, +10, +18, +26: commit lands on edge r1+26
    wait_cyc(r1 + 25);
    rd(2'd1, d);
    check("seg1_pre_commit", d & 32'h0000_0202, 32'h0000_0200);
    rd(2'd1, d);
    check("seg1_post_commit", d & 32'h0000_0202, 32'h0000_0002);
    check("post_rst_irq", {31'b0, irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg7_readback.md
# seg7_readback

- Memory-mapped readback monitor for the eight 7-segment display buses (`seg0`..`seg7`) driven by `nios_system`.
- Scans the buses round-robin and debounces each pattern over repeated visits.
- Decodes stable patterns back to hex nibbles and exposes them, with valid/blank/change status and an interrupt, on an Avalon-MM slave.
- Gives the CPU, and self-checking firmware tests, a view of what the display actually shows.

## Interface
Parameters:
- `STABLE_COUNT`, 4: consecutive identical visits before a pattern commits; legal range 1..255.

Ports:
- `clk_clk`  in  1  system clock; all logic on the rising edge.
- `reset_reset_n`  in  1  asynchronous, active-low reset.
- `seg0_export`..`seg7_export`  in  7 each  segment buses, same clock domain; active-low; bit0=a … bit6=g.
- `avs_address`  in  2  word address.
- `avs_read`  in  1  read strobe.
- `avs_readdata`  out  32  read data, fixed read latency 1.
- `avs_write`  in  1  write strobe.
- `avs_writedata`  in  32  write data.
- `irq`  out  1  level interrupt, active-high.

## Operation
- **Scan index.** 3-bit, 0→7→0, advances every cycle; the digit at the index is visited that cycle.
- **Per-digit state.** `last` (7 bits) and `cnt` (8 bits). On a visit:
  - If raw ≠ `last`: set `last`←raw and `cnt`←1.
  - Else, if `cnt` ≠ `STABLE_COUNT`: `cnt`++.
  - Commit happens when the new `cnt` equals `STABLE_COUNT` and the old one did not. With `STABLE_COUNT`=1, the mismatch visit commits.
- **Decode (active-low).**
  - Hex values: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (all hex).
  - 7F → blank.
  - Any other pattern → invalid.
- **Commit.** Writes nibble (0 when blank or invalid), `valid[i]` and `blank[i]`. Sets `change[i]` if any of the three differs from the previously committed value.
- **Registers.**
  - 0 DIGITS (RO): nibble i at bits [4i+3:4i].
  - 1 STATUS (RO): [7:0] valid, [15:8] blank, rest 0.
  - 2 CHANGE: [7:0] sticky flags; write 1 to clear (W1C).
  - 3 IRQ_EN (RW): [7:0].
  - Writes to RO registers are ignored.
- **Interrupt.** `irq` = registered OR of (CHANGE & IRQ_EN).
- **Simultaneous events.**
  - A commit that sets `change[i]` in the same cycle as a W1C of bit i leaves the bit set (set wins).
  - A read and a commit in the same cycle return the pre-commit value.
- **Reset values.**
  - Scan index 0.
  - `last`=7F, `cnt`=`STABLE_COUNT`.
  - DIGITS 0, valid 00, blank FF, CHANGE 00, IRQ_EN 00.
  - `irq` 0, `avs_readdata` 0.
- **Reset mid-operation.** Asynchronously returns everything to the reset values. No partial commit survives.

## Timing
- **Read.** `avs_readdata` is valid the cycle after `avs_read`. It holds its last value when there is no read.
- **Write.** Takes effect at the edge on which `avs_write` is sampled.
- **Commit latency.** A pattern first sampled on a visit at cycle t commits at the edge ending cycle t+8·(`STABLE_COUNT`−1). It is readable from the next cycle.
- **Worst case from bus change to commit.** 7 + 8·(`STABLE_COUNT`−1) + 1 cycles.
- **Interrupt latency.** `irq` rises one cycle after the `change` bit sets. It falls one cycle after the last enabled bit clears or after IRQ_EN is cleared.
- **Bouncing input.** A pattern that changes between visits restarts the count. A glitch shorter than one scan period may go unseen.

## Structure
- **Package `seg7_pkg`.**
  - 7-bit segment constants for 0–F and blank.
  - Register address constants: `REG_DIGITS`, `REG_STATUS`, `REG_CHANGE`, `REG_IRQ_EN`.
  - Decode result struct: nibble, valid, blank.
- **Sub-module `seg7_decode`.** Combinational pattern → decode result. One instance, shared through the scan multiplexer.

## Test plan
- **Reset.** Hold all segment inputs at 7F through reset. All registers read their reset values (DIGITS 0, STATUS 0000FF00, CHANGE 0), `irq`=0, and no change bit is ever set.
- **Full commit.** `STABLE_COUNT`=4; drive seg0..seg7 = 40,79,24,30,19,12,02,78. After ≤32 cycles DIGITS reads 76543210, STATUS reads 000000FF and CHANGE reads FF.
- **Debounce.** Toggle seg3 between 00 and 10 every 8 cycles: DIGITS[15:12] never commits. Then hold 10: it commits 9 within 32 cycles and sets `change[3]`.
- **Invalid pattern.** Drive seg5=55. After commit, `valid[5]`=0, `blank[5]`=0 and nibble 5 = 0.
- **Interrupt.** IRQ_EN=04, change seg2: `irq` rises one cycle after `change[2]` sets. Write CHANGE=04: `irq` falls next cycle. A commit on seg2 in the same cycle as the W1C leaves the bit set.
- **Reset mid-debounce.** Assert reset with seg1 at `cnt`=2. All state returns to reset values, and the pattern needs a full 4 visits again after release.
